// File: rtl/shift_reg_param.sv
// ---------------------------------------------------------------------------
// shift_reg_param
//   Parametrised shift register with parallel load, serial in/out, selectable
//   bit order and a built-in frame bit counter. This is the common datapath
//   for the UART TX (parallel-in, serial-out) and RX (serial-in, parallel-out)
//   paths. The block tracks frame progress itself, so the surrounding control
//   logic only has to issue shift strobes.
//
// Parameters
//   WIDTH     : frame width in bits (>= 2)
//   LSB_FIRST : 1 = shift right (bit 0 leaves first, serial_in enters MSB)
//               0 = shift left  (MSB leaves first, serial_in enters bit 0)
//   IDLE_VAL  : serial_out level while no frame is in progress
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   load       in   load D into Q and start a frame (highest priority)
//   start      in   start a frame without touching Q (receive use)
//   D          in   parallel load data
//   shift_en   in   one-cycle shift strobe (e.g. baud tick)
//   serial_in  in   serial bit entering the register
//   serial_out out  serial bit leaving the register (IDLE_VAL when idle)
//   Q          out  parallel register contents
//   count      out  bits shifted so far in the current frame
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the last bit of a frame shifts
// ---------------------------------------------------------------------------
module shift_reg_param #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter bit          IDLE_VAL  = 1'b1,
    localparam int unsigned CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             start,
    input  logic [WIDTH-1:0] D,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] Q,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Count value at which the next strobe shifts the final bit of the frame.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] data_shifted;

    // Register contents after one shift in the configured direction.
    always_comb begin
        if (LSB_FIRST) begin
            data_shifted = {serial_in, data_q[WIDTH-1:1]};
        end else begin
            data_shifted = {data_q[WIDTH-2:0], serial_in};
        end
    end

    // Next-state logic. Priority is load > start > shift_en; shift_en only
    // acts while a frame is in progress.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        done_d  = 1'b0;

        if (load) begin
            // Also restarts a running frame; an aborted frame never reports done.
            data_d  = D;
            count_d = '0;
            state_d = SHIFT;
        end else if (start) begin
            count_d = '0;
            state_d = SHIFT;
        end else if (state_q == SHIFT && shift_en) begin
            data_d = data_shifted;
            if (count_q == LAST_CNT) begin
                // Final bit: the count wraps here, so it never shows WIDTH.
                count_d = '0;
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // NOTE: the reset clears the data register too, because Q is a visible
    // output and must read zero straight after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign Q     = data_q;
    assign count = count_q;
    assign busy  = (state_q == SHIFT);
    assign done  = done_q;

    // Taken from registered state only, so the first bit of a loaded word is
    // on the line in the cycle right after load.
    assign serial_out = busy ? (LSB_FIRST ? data_q[0] : data_q[WIDTH-1]) : IDLE_VAL;

endmodule

// File: tb/tb_shift_reg_param.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_param
//   Directed bench for shift_reg_param. One instance shifts LSB first, a
//   second instance shifts MSB first. Inputs change 1 ns after the rising
//   edge and outputs are checked at that point too, so they are stable.
// ---------------------------------------------------------------------------
module tb_shift_reg_param;

    logic       clk;
    logic       rst;

    // LSB-first instance
    logic       load, start, shift_en, serial_in;
    logic [7:0] d;
    logic       serial_out;
    logic [7:0] q;
    logic [2:0] count;
    logic       busy, done;

    // MSB-first instance
    logic       m_load, m_start, m_shift_en, m_serial_in;
    logic [7:0] m_d;
    logic       m_serial_out;
    logic [7:0] m_q;
    logic [2:0] m_count;
    logic       m_busy, m_done;

    int total = 0;
    int bad   = 0;

    shift_reg_param #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_VAL(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .start      (start),
        .D          (d),
        .shift_en   (shift_en),
        .serial_in  (serial_in),
        .serial_out (serial_out),
        .Q          (q),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    shift_reg_param #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_VAL(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .load       (m_load),
        .start      (m_start),
        .D          (m_d),
        .shift_en   (m_shift_en),
        .serial_in  (m_serial_in),
        .serial_out (m_serial_out),
        .Q          (m_q),
        .count      (m_count),
        .busy       (m_busy),
        .done       (m_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe on the LSB-first instance with a given serial_in bit.
    task automatic strobe(input logic bit_in);
        serial_in = bit_in;
        shift_en  = 1'b1;
        tick();
        shift_en  = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] tx_byte;
        logic [7:0] rx_bits;
        logic [7:0] msb_exp;
        int         done_seen;

        tx_byte = 8'hA5;
        rx_bits = 8'b0011_1100;   // rx_bits[i] is the i-th serial bit fed in
        msb_exp = 8'b1000_0001;   // msb_exp[i] is the i-th bit expected out

        load = 1'b0; start = 1'b0; shift_en = 1'b0; serial_in = 1'b0; d = 8'h00;
        m_load = 1'b0; m_start = 1'b0; m_shift_en = 1'b0; m_serial_in = 1'b0; m_d = 8'h00;
        rst = 1'b1;

        // ---------------- reset values ----------------
        #1 rst = 1'b0;
        #1;
        check("rst_q",     32'(q),          32'h00);
        check("rst_count", 32'(count),      32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_sout",  32'(serial_out), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ---------------- TX, LSB first, 0xA5, strobe every 4 cycles ----------------
        d = 8'hA5; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_sout%0d", i),  32'(serial_out), 32'(tx_byte[i]));
            check($sformatf("tx_count%0d", i), 32'(count),      32'(i));
            check($sformatf("tx_busy%0d", i),  32'(busy),       32'd1);
            check($sformatf("tx_done%0d", i),  32'(done),       32'd0);
            repeat (3) tick();
            strobe(1'b0);
        end
        check("tx_done",      32'(done),       32'd1);
        check("tx_busy_end",  32'(busy),       32'd0);
        check("tx_sout_idle", 32'(serial_out), 32'd1);
        check("tx_count_end", 32'(count),      32'd0);
        tick();
        check("tx_done_pulse", 32'(done), 32'd0);

        // ---------------- RX, LSB first, expect 0x3C ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rx_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rx_count%0d", i), 32'(count), 32'(i));
            check($sformatf("rx_done%0d", i),  32'(done),  32'd0);
            tick();
            strobe(rx_bits[i]);
        end
        check("rx_done",      32'(done),  32'd1);
        check("rx_q",         32'(q),     32'h3C);
        check("rx_count_end", 32'(count), 32'd0);
        check("rx_busy_end",  32'(busy),  32'd0);
        serial_in = 1'b0;
        tick();

        // ---------------- MSB first, 0x81 ----------------
        m_d = 8'h81; m_load = 1'b1;
        tick();
        m_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("msb_sout%0d", i),  32'(m_serial_out), 32'(msb_exp[i]));
            check($sformatf("msb_count%0d", i), 32'(m_count),      32'(i));
            check($sformatf("msb_done%0d", i),  32'(m_done),       32'd0);
            m_shift_en = 1'b1;
            tick();
            m_shift_en = 1'b0;
        end
        check("msb_done",      32'(m_done),       32'd1);
        check("msb_busy_end",  32'(m_busy),       32'd0);
        check("msb_sout_idle", 32'(m_serial_out), 32'd1);
        tick();
        check("msb_done_pulse", 32'(m_done), 32'd0);

        // ---------------- restart with load mid-frame ----------------
        d = 8'hFF; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) strobe(1'b0);
        check("rs_count3", 32'(count), 32'd3);
        d = 8'h00; load = 1'b1;
        tick();
        load = 1'b0;
        check("rs_count0", 32'(count), 32'd0);
        check("rs_busy",   32'(busy),  32'd1);
        check("rs_nodone", 32'(done),  32'd0);
        check("rs_q",      32'(q),     32'h00);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rs_sout%0d", i), 32'(serial_out), 32'd0);
            strobe(1'b0);
            if (done) done_seen++;
        end
        tick();
        if (done) done_seen++;
        check("rs_done_count", 32'(done_seen), 32'd1);
        check("rs_busy_end",   32'(busy),      32'd0);

        // ---------------- shift_en ignored in IDLE ----------------
        serial_in = 1'b1; shift_en = 1'b1;
        tick();
        tick();
        shift_en = 1'b0; serial_in = 1'b0;
        check("idle_q",     32'(q),          32'h00);
        check("idle_count", 32'(count),      32'd0);
        check("idle_busy",  32'(busy),       32'd0);
        check("idle_sout",  32'(serial_out), 32'd1);
        check("idle_done",  32'(done),       32'd0);

        // ---------------- load and start together ----------------
        d = 8'h5A; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        check("prio_q",     32'(q),          32'h5A);
        check("prio_busy",  32'(busy),       32'd1);
        check("prio_count", 32'(count),      32'd0);
        check("prio_sout",  32'(serial_out), 32'd0);

        // ---------------- asynchronous reset mid-frame at count 4 ----------------
        for (int i = 0; i < 4; i++) strobe(1'b1);
        check("mr_count4", 32'(count), 32'd4);
        #2 rst = 1'b0;
        #1;
        check("mr_q",     32'(q),          32'h00);
        check("mr_count", 32'(count),      32'd0);
        check("mr_busy",  32'(busy),       32'd0);
        check("mr_done",  32'(done),       32'd0);
        check("mr_sout",  32'(serial_out), 32'd1);
        #3 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1);
            check($sformatf("mr_post_done%0d", i), 32'(done), 32'd0);
            check($sformatf("mr_post_busy%0d", i), 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
